n_clic_unit: RTL and testbench

- Nested, vectored core-local interrupt controller with hardware priority nesting.
- Holds per-vector CSRs (pend, enable, priority, handler address), `mstatus`, and an interrupt threshold.
- Selects the highest-priority pending and enabled vector. When its priority exceeds the current level, it overrides the next PC with the handler address.
- Keeps a stack of preempted PCs and levels; a jump to the all-ones address acts as interrupt return.
- Sits between the PC-next logic and the PC branch mux; CSR port is shared with the CSR instruction path.

---
 rtl/n_clic_unit_pkg.sv | 40 ++++
 rtl/n_clic_unit_if.sv | 28 ++
 rtl/n_clic_unit_csr.sv | 37 +++
 rtl/n_clic_unit.sv | 172 +++++++++++++++++
 tb/tb_n_clic_unit.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/n_clic_unit_pkg.sv
// Shared types and configuration for the nested vectored interrupt controller.
// Optional threshold CSR is enabled by defining N_CLIC_MINTTHRESH_EN.
package n_clic_unit_pkg;

    localparam int VecSize       = 8;
    localparam int PrioWidth     = 3;
    localparam int VecWidth      = 10;
    localparam int IMemAddrWidth = 32;
    localparam int EntryWidth    = PrioWidth + 2;
    localparam int StackDepth    = 1 << PrioWidth;
    localparam int VecIdxWidth   = $clog2(VecSize);

    typedef logic [11:0]              CsrAddrT;
    typedef logic [4:0]               r;
    typedef logic [31:0]              word;
    typedef logic [PrioWidth-1:0]     PrioT;
    typedef logic [IMemAddrWidth-1:0] IMemAddrT;
    typedef logic [VecIdxWidth-1:0]   VecIdxT;

    localparam CsrAddrT VecCsrBase     = 12'hB00;
    localparam CsrAddrT EntryCsrBase   = 12'hB20;
    localparam CsrAddrT MStatusAddr    = 12'h300;
    localparam CsrAddrT MIntThreshAddr = 12'h347;

    typedef enum logic [2:0] {
        CSRRW  = 3'b001,
        CSRRS  = 3'b010,
        CSRRC  = 3'b011,
        CSRRWI = 3'b101,
        CSRRSI = 3'b110,
        CSRRCI = 3'b111
    } csr_op_t;

    typedef enum logic [1:0] {
        PC_NORMAL    = 2'd0,
        PC_INTERRUPT = 2'd1,
        PC_RETURN    = 2'd2
    } pc_interrupt_mux_t;

endpackage

// File: rtl/n_clic_unit_if.sv
// CSR and PC-path signal bundle of the interrupt controller.
// master drives CSR/PC inputs, slave is the controller side.
interface n_clic_unit_if;
    import n_clic_unit_pkg::*;

    logic              csr_enable;
    CsrAddrT           csr_addr;
    r                  rs1_zimm;
    word               rs1_data;
    csr_op_t           csr_op;
    IMemAddrT          pc_in;
    word               csr_out;
    IMemAddrT          int_addr;
    pc_interrupt_mux_t pc_interrupt_sel;
    PrioT              level_out;
    logic              interrupt_out;

    modport master (
        output csr_enable, csr_addr, rs1_zimm, rs1_data, csr_op, pc_in,
        input  csr_out, int_addr, pc_interrupt_sel, level_out, interrupt_out
    );

    modport slave (
        input  csr_enable, csr_addr, rs1_zimm, rs1_data, csr_op, pc_in,
        output csr_out, int_addr, pc_interrupt_sel, level_out, interrupt_out
    );

endinterface

// File: rtl/n_clic_unit_csr.sv
// Generic width-W CSR with RW/RS/RC read-modify-write and a hardware clear mask
// that wins over a same-cycle software write.
module n_clic_csr
    import n_clic_unit_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  csr_op_t      op,
    input  logic [W-1:0] operand,
    input  logic [W-1:0] hw_clr,
    output logic [W-1:0] q
);

    logic [W-1:0] nxt;

    always_comb begin
        nxt = q;
        unique case (op)
            CSRRW, CSRRWI: nxt = operand;
            CSRRS, CSRRSI: nxt = q | operand;
            CSRRC, CSRRCI: nxt = q & ~operand;
            default:       nxt = q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= (wr ? nxt : q) & ~hw_clr;
        end
    end

endmodule

// File: rtl/n_clic_unit.sv
// Nested vectored interrupt controller: priority select, PC override and a
// stack of preempted PCs/levels. Define N_CLIC_MINTTHRESH_EN for the threshold CSR.
module n_clic_unit
    import n_clic_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    n_clic_unit_if.slave bus
);

    logic [EntryWidth-1:0] ent [VecSize];
    logic [EntryWidth-1:0] ent_clr [VecSize];
    logic [VecWidth-1:0]   vec [VecSize];
    logic                  ent_we [VecSize];
    logic                  vec_we [VecSize];
    logic                  mie;
    logic                  ms_we;
    PrioT                  thresh;
    word                   operand;
    logic                  unused_bits;

    PrioT                  max_prio;
    VecIdxT                max_vec;
    logic                  take_cond;
    logic                  ret;
    logic                  take;

    PrioT                  level;
    logic [PrioWidth:0]    sp;
    PrioT                  top;
    IMemAddrT              stack_pc [StackDepth];
    PrioT                  stack_lvl [StackDepth];

    always_comb begin
        operand = bus.rs1_data;
        if (bus.csr_op inside {CSRRWI, CSRRSI, CSRRCI}) begin
            operand = word'(bus.rs1_zimm);
        end
    end

    assign unused_bits = ^operand[31:VecWidth];
    assign ms_we = bus.csr_enable && (bus.csr_addr == MStatusAddr);

    for (genvar i = 0; i < VecSize; i++) begin : g_vec
        assign ent_we[i] = bus.csr_enable
                        && (bus.csr_addr == EntryCsrBase + CsrAddrT'(i));
        assign vec_we[i] = bus.csr_enable
                        && (bus.csr_addr == VecCsrBase + CsrAddrT'(i));
        // Only the pend bit is cleared by hardware, on the winner's take.
        assign ent_clr[i] = EntryWidth'(take && (max_vec == VecIdxT'(i)));

        n_clic_csr #(.W(EntryWidth)) u_ent (
            .clk     (clk),
            .reset   (reset),
            .wr      (ent_we[i]),
            .op      (bus.csr_op),
            .operand (operand[EntryWidth-1:0]),
            .hw_clr  (ent_clr[i]),
            .q       (ent[i])
        );

        n_clic_csr #(.W(VecWidth)) u_vec (
            .clk     (clk),
            .reset   (reset),
            .wr      (vec_we[i]),
            .op      (bus.csr_op),
            .operand (operand[VecWidth-1:0]),
            .hw_clr  ('0),
            .q       (vec[i])
        );
    end

    n_clic_csr #(.W(1)) u_mstatus (
        .clk     (clk),
        .reset   (reset),
        .wr      (ms_we),
        .op      (bus.csr_op),
        .operand (operand[3]),
        .hw_clr  (1'b0),
        .q       (mie)
    );

`ifdef N_CLIC_MINTTHRESH_EN
    logic thr_we;
    assign thr_we = bus.csr_enable && (bus.csr_addr == MIntThreshAddr);

    n_clic_csr #(.W(PrioWidth)) u_thresh (
        .clk     (clk),
        .reset   (reset),
        .wr      (thr_we),
        .op      (bus.csr_op),
        .operand (operand[PrioWidth-1:0]),
        .hw_clr  ('0),
        .q       (thresh)
    );
`else
    assign thresh = '0;
`endif

    // Strict '>' makes ties resolve to the lowest index.
    always_comb begin
        max_prio = '0;
        max_vec  = '0;
        for (int i = 0; i < VecSize; i++) begin
            if (ent[i][0] && ent[i][1]
                && (ent[i][EntryWidth-1:2] > max_prio)) begin
                max_prio = ent[i][EntryWidth-1:2];
                max_vec  = VecIdxT'(i);
            end
        end
    end

    assign top       = sp[PrioWidth-1:0] - PrioT'(1);
    assign take_cond = mie && (max_prio > level) && (max_prio > thresh);
    assign ret       = (bus.pc_in == '1) && (sp != '0);
    assign take      = take_cond && !ret;

    always_comb begin
        bus.int_addr         = bus.pc_in;
        bus.pc_interrupt_sel = PC_NORMAL;
        bus.interrupt_out    = 1'b0;
        if (ret) begin
            bus.int_addr         = stack_pc[top];
            bus.pc_interrupt_sel = PC_RETURN;
        end else if (take_cond) begin
            bus.int_addr         = IMemAddrT'({vec[max_vec], 2'b00});
            bus.pc_interrupt_sel = PC_INTERRUPT;
            bus.interrupt_out    = 1'b1;
        end
    end

    always_comb begin
        bus.csr_out = '0;
        if (bus.csr_addr == MStatusAddr) begin
            bus.csr_out = word'({mie, 3'b000});
        end
        if (bus.csr_addr == MIntThreshAddr) begin
            bus.csr_out = word'(thresh);
        end
        for (int i = 0; i < VecSize; i++) begin
            if (bus.csr_addr == VecCsrBase + CsrAddrT'(i)) begin
                bus.csr_out = word'(vec[i]);
            end
            if (bus.csr_addr == EntryCsrBase + CsrAddrT'(i)) begin
                bus.csr_out = word'(ent[i]);
            end
        end
    end

    assign bus.level_out = level;

    // Levels strictly rise on every push, so sp never exceeds StackDepth-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= '0;
            sp    <= '0;
            for (int i = 0; i < StackDepth; i++) begin
                stack_pc[i]  <= '0;
                stack_lvl[i] <= '0;
            end
        end else if (ret) begin
            sp    <= sp - 1'b1;
            level <= stack_lvl[top];
        end else if (take) begin
            stack_pc[sp[PrioWidth-1:0]]  <= bus.pc_in;
            stack_lvl[sp[PrioWidth-1:0]] <= level;
            sp    <= sp + 1'b1;
            level <= max_prio;
        end
    end

endmodule

// File: tb/tb_n_clic_unit.sv
// Directed scoreboard bench for n_clic_unit: PC is fed back through a register,
// expectations are queued by the stimulus and checked by a monitor.
module tb_n_clic_unit;
    import n_clic_unit_pkg::*;

    typedef struct {
        string             nm;
        IMemAddrT          a;
        pc_interrupt_mux_t s;
        PrioT              l;
        logic              i;
        word               c;
    } exp_t;

`ifdef N_CLIC_MINTTHRESH_EN
    localparam word THR = 32'd3;
`else
    localparam word THR = 32'd0;
`endif

    logic     clk = 1'b0;
    logic     reset = 1'b1;
    logic     brk = 1'b0;
    IMemAddrT pc_reg = 32'h100;
    exp_t     sb [$];
    int       total = 0;
    int       bad = 0;

    n_clic_unit_if bus ();

    n_clic_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pc_reg <= bus.int_addr;
    assign bus.pc_in = brk ? '1 : pc_reg;

    task automatic chk(input string nm, input string f,
                       input word act, input word exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", nm, f, act, exp);
        end
    endtask

    task automatic cyc(input string nm, input logic rs, input logic en,
                       input CsrAddrT ad, input csr_op_t op, input word d,
                       input r z, input logic br, input IMemAddrT ea,
                       input pc_interrupt_mux_t es, input PrioT el,
                       input logic ei, input word ec);
        exp_t e;
        @(negedge clk);
        reset          = rs;
        bus.csr_enable = en;
        bus.csr_addr   = ad;
        bus.csr_op     = op;
        bus.rs1_data   = d;
        bus.rs1_zimm   = z;
        brk            = br;
        e.nm = nm; e.a = ea; e.s = es; e.l = el; e.i = ei; e.c = ec;
        sb.push_back(e);
    endtask

    always begin
        exp_t e;
        @(negedge clk);
        #2;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            chk(e.nm, "int_addr", bus.int_addr, e.a);
            chk(e.nm, "sel", word'(bus.pc_interrupt_sel), word'(e.s));
            chk(e.nm, "level", word'(bus.level_out), word'(e.l));
            chk(e.nm, "irq", word'(bus.interrupt_out), word'(e.i));
            chk(e.nm, "csr_out", bus.csr_out, e.c);
        end
    end

    CsrAddrT sa [9] = '{12'hB20, 12'hB22, 12'hB24, 12'hB27,
                        12'hB00, 12'hB02, 12'hB04, 12'hB07, 12'h300};
    word     sv [9] = '{32'd6, 32'd10, 32'd6, 32'd30,
                        32'd2, 32'd4, 32'd8, 32'd14, 32'd8};

    initial begin
        bus.csr_enable = 1'b0;
        bus.csr_addr   = 12'hB20;
        bus.csr_op     = CSRRW;
        bus.rs1_data   = '0;
        bus.rs1_zimm   = '0;

        cyc("rst0", 1, 0, 12'hB20, CSRRW, 0, 0, 0, 32'h100, PC_NORMAL, 0, 0, 0);
        cyc("rst1", 1, 0, 12'hB00, CSRRW, 0, 0, 0, 32'h100, PC_NORMAL, 0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            cyc("setup", 0, 1, sa[k], CSRRW, sv[k], 0, 0,
                32'h100, PC_NORMAL, 0, 0, 0);
        end

        cyc("pend4", 0, 1, 12'hB24, CSRRSI, 0, 1, 0, 32'h100, PC_NORMAL, 0, 0, 6);
        cyc("take4", 0, 0, 12'hB24, CSRRW, 0, 0, 0, 32, PC_INTERRUPT, 0, 1, 7);
        cyc("pend0", 0, 1, 12'hB20, CSRRSI, 0, 1, 0, 32, PC_NORMAL, 1, 0, 6);
        cyc("eqlvl", 0, 0, 12'hB24, CSRRW, 0, 0, 0, 32, PC_NORMAL, 1, 0, 6);
        cyc("pend2", 0, 1, 12'hB22, CSRRSI, 0, 1, 0, 32, PC_NORMAL, 1, 0, 10);
        cyc("take2", 0, 0, 12'hB22, CSRRW, 0, 0, 0, 16, PC_INTERRUPT, 1, 1, 11);
        cyc("clr2", 0, 0, 12'hB22, CSRRW, 0, 0, 0, 16, PC_NORMAL, 2, 0, 10);
        cyc("pend7", 0, 1, 12'hB27, CSRRSI, 0, 1, 0, 16, PC_NORMAL, 2, 0, 30);
        cyc("take7", 0, 0, 12'hB27, CSRRW, 0, 0, 0, 56, PC_INTERRUPT, 2, 1, 31);
        cyc("ret7", 0, 0, 12'hB27, CSRRW, 0, 0, 1, 16, PC_RETURN, 7, 0, 30);
        cyc("lvl2", 0, 0, 12'hB00, CSRRW, 0, 0, 0, 16, PC_NORMAL, 2, 0, 2);

        cyc("rsi0", 0, 1, 12'hB00, CSRRSI, 0, 0, 0, 16, PC_NORMAL, 2, 0, 2);
        cyc("rsi1", 0, 1, 12'hB01, CSRRSI, 0, 0, 0, 16, PC_NORMAL, 2, 0, 0);
        cyc("rsi2", 0, 1, 12'hB02, CSRRSI, 0, 0, 0, 16, PC_NORMAL, 2, 0, 4);
        cyc("rsims", 0, 1, 12'h300, CSRRSI, 0, 0, 0, 16, PC_NORMAL, 2, 0, 8);
        cyc("held2", 0, 0, 12'hB02, CSRRW, 0, 0, 0, 16, PC_NORMAL, 2, 0, 4);

        cyc("rw", 0, 1, 12'hB02, CSRRW, 32'h0FFFFFFF, 0, 0,
            16, PC_NORMAL, 2, 0, 4);
        cyc("trunc", 0, 0, 12'hB02, CSRRW, 0, 0, 0, 16, PC_NORMAL, 2, 0, 32'h3FF);
        cyc("hold", 0, 0, 12'hB02, CSRRW, 0, 0, 0, 16, PC_NORMAL, 2, 0, 32'h3FF);

        cyc("ret2", 0, 0, 12'hB20, CSRRW, 0, 0, 1, 32, PC_RETURN, 2, 0, 7);
        cyc("lvl1", 0, 0, 12'hB20, CSRRW, 0, 0, 0, 32, PC_NORMAL, 1, 0, 7);

        cyc("mrst", 1, 0, 12'hB02, CSRRW, 0, 0, 0, 32, PC_NORMAL, 0, 0, 0);
        cyc("mrste", 1, 0, 12'hB20, CSRRW, 0, 0, 0, 32, PC_NORMAL, 0, 0, 0);
        cyc("mrstm", 1, 0, 12'h300, CSRRW, 0, 0, 0, 32, PC_NORMAL, 0, 0, 0);
        cyc("empty", 0, 0, 12'hB27, CSRRW, 0, 0, 1, '1, PC_NORMAL, 0, 0, 0);
        cyc("thrw", 0, 1, 12'h347, CSRRW, 3, 0, 0, '1, PC_NORMAL, 0, 0, 0);
        cyc("thrr", 0, 0, 12'h347, CSRRW, 0, 0, 0, '1, PC_NORMAL, 0, 0, THR);

        @(negedge clk);
        @(negedge clk);
        #3;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
